ddr3_stream_wr_dma: RTL
=======================

// Module: ddr3_stream_wr_dma
// PURPOSE
//  Write DMA directly upstream of the AXI DDR3 controller's s_axi slave port.
//  Accepts a valid/ready stream of 32-bit samples, buffers them in a FIFO and issues INCR bursts on an AXI4 master write channel.
//  Writes land in a word-aligned DDR3 region given by base_addr/num_words. Read channels are not driven; tie them off at the top level.
// PARAMETERS
//  C_ID_WIDTH    3    AXI ID width; awid is constant 0
//  C_BURST_LEN   16   words per full burst, power of 2 in 2..256; awlen = C_BURST_LEN-1
//  C_FIFO_DEPTH  64   stream FIFO depth in words, power of 2, >= 2*C_BURST_LEN
//  C_CNT_WIDTH   24   width of num_words and of the internal word counters
// PORTS
//  clk            in   1    single clock; AXI clock of the controller
//  aresetn        in   1    asynchronous active-low reset
//  phy_init_done  in   1    controller calibration complete
//  start          in   1    level; sampled in IDLE
//  base_addr      in   32   byte address; [1:0]=0 and aligned to C_BURST_LEN*4
//  num_words      in   C_CNT_WIDTH  words to write
//  busy           out  1    high outside IDLE
//  done           out  1    one-cycle pulse at end of transfer (or pass)
//  err            out  1    sticky: some bresp != OKAY; cleared on accepted start
//  s_data         in   32   stream data
//  s_valid/s_ready in/out 1  stream handshake
//  m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  AXI4 widths; awready in
//  m_axi_w{data,strb,last,valid}  out  32/4/1/1; wready in
//  m_axi_b{id,resp,valid}  in  C_ID_WIDTH/2/1; bready out
// BEHAVIOUR
//  Reset: all outputs 0; FIFO flushed; state IDLE. A reset asserted mid-burst abandons the burst.
//  Constants: awsize=3'b010, awburst=INCR, awlock=0, awcache=4'b0011, awprot=0, awqos=0, wstrb=4'hF.
//  s_ready = FIFO not full, in every state (including IDLE). A word is pushed when s_valid&&s_ready.
//  FSM:
//   IDLE: start=1 -> WAIT_INIT. Latch base_addr/num_words. Clear err.
//   WAIT_INIT: phy_init_done=1 -> DONE if num_words==0, else ADDR. No cycle limit.
//   ADDR: blen = min(C_BURST_LEN, remaining). Assert awvalid only when FIFO count >= blen; awaddr/awlen hold while awvalid&&!awready. Handshake -> DATA.
//   DATA: wvalid=1 for blen beats; wlast on beat blen. Last beat accepted -> RESP.
//   RESP: bready=1. On bvalid: err|=(bresp!=0); addr+=blen*4; remaining-=blen. remaining==0 -> DONE, else ADDR.
//   DONE: done=1 for exactly 1 cycle -> IDLE.
//  One burst outstanding at a time; an AW is never issued before the B of the previous burst.
//  Bursts never cross 4KB because base_addr is burst-aligned; an unaligned base_addr is a caller error, not checked.
//  Simultaneous FIFO push and pop keep the count unchanged; FIFO full -> s_ready=0 next cycle, no data loss.
//  Words arriving beyond num_words stay in the FIFO for the next transfer.
//  start while busy: ignored. An SLVERR response does not abort the transfer.
// CONFIGURATION
//  RING_BUF_EN defined: in DONE, if start==1 then reload addr=base_addr and remaining=num_words, pulse done, go to ADDR (continuous ring).
//   With start==0, go to IDLE. err is not cleared on wrap.
//  RING_BUF_EN undefined: DONE always returns to IDLE.
// STRUCTURE
//  Package ddr3_wr_dma_pkg:
//   AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY.
//   state enum {IDLE,WAIT_INIT,ADDR,DATA,RESP,DONE}.
//  Sub-module ddr3_wr_dma_fifo: sync FIFO, registered output; ports: push/pop/full/empty/count.
// TESTING
//  1. num_words=32, base=0xA4000000, stream 0..31 -> AW 0xA4000000/len15 and 0xA4000040/len15; W data 0..31; done 1 pulse.
//  2. num_words=20 -> bursts len15 then len3 at +0x40; wlast on beats 16 and 20.
//  3. phy_init_done=0 for 100 cycles after start -> no awvalid until it rises; busy=1 throughout.
//  4. bresp=2'b10 on burst 1 of 2 -> transfer completes; err=1 until next start.
//  5. Random awready/wready/bvalid stalls, s_valid 50% -> data in order, FIFO never overflows.
//  6. aresetn low during DATA beat 5 -> outputs 0 immediately; a new start writes cleanly. RING_BUF_EN + start held -> address wraps to base.

Source files
------------

// File: rtl/ddr3_wr_dma_pkg.sv
// Shared AXI encodings and FSM state type for the DDR3 stream write DMA.
package ddr3_wr_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        ADDR,
        DATA,
        RESP,
        DONE
    } state_t;

endpackage

// File: rtl/ddr3_wr_dma_fifo.sv
// Synchronous stream FIFO; pop_data is read straight from the storage flops at the read pointer.
module ddr3_wr_dma_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push and pop in the same cycle leave the occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ddr3_stream_wr_dma.sv
// Stream-to-AXI4 write DMA feeding the DDR3 controller, one INCR burst outstanding at a time.
// Define RING_BUF_EN to restart from base_addr in DONE while start is held (continuous ring).
module ddr3_stream_wr_dma
    import ddr3_wr_dma_pkg::*;
#(
    parameter int C_ID_WIDTH   = 3,
    parameter int C_BURST_LEN  = 16,
    parameter int C_FIFO_DEPTH = 64,
    parameter int C_CNT_WIDTH  = 24
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   phy_init_done,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [C_CNT_WIDTH-1:0] num_words,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [C_ID_WIDTH-1:0]  m_axi_awid,
    output logic [31:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awlock,
    output logic [3:0]             m_axi_awcache,
    output logic [2:0]             m_axi_awprot,
    output logic [3:0]             m_axi_awqos,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [31:0]            m_axi_wdata,
    output logic [3:0]             m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [C_ID_WIDTH-1:0]  m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready
);

    localparam int FIFO_AW = $clog2(C_FIFO_DEPTH);
    localparam logic [C_CNT_WIDTH-1:0] BURST_WORDS = C_CNT_WIDTH'(C_BURST_LEN);

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [C_CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [8:0]             beat_q, beat_d;
    logic                   err_q, err_d;
    logic                   ready_en_q;

    logic [C_CNT_WIDTH-1:0] blen;
    logic [FIFO_AW:0]       fifo_count;
    logic [31:0]            fifo_data;
    logic                   fifo_full, fifo_empty;
    logic                   last_beat;
    logic                   unused_inputs;

    ddr3_wr_dma_fifo #(
        .DEPTH (C_FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (m_axi_wvalid && m_axi_wready),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign blen      = (remaining_q < BURST_WORDS) ? remaining_q : BURST_WORDS;
    assign last_beat = (beat_q == 9'(blen - 1'b1));

    assign busy          = (state_q != IDLE);
    assign err           = err_q;
    assign s_ready       = ready_en_q && !fifo_full;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = (state_q == ADDR) ? addr_q : 32'd0;
    assign m_axi_awlen   = (state_q == ADDR) ? 8'(blen - 1'b1) : 8'd0;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_BUF;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wdata   = (state_q == DATA) ? fifo_data : 32'd0;
    assign m_axi_wlast   = (state_q == DATA) && last_beat;
    assign unused_inputs = ^{m_axi_bid, fifo_empty};

    // AW waits for a whole burst in the FIFO, so W never stalls on the stream side
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        beat_d        = beat_q;
        err_d         = err_q;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_INIT;
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    err_d       = 1'b0;
                end
            end
            WAIT_INIT: begin
                if (phy_init_done) begin
                    state_d = (remaining_q == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid = (C_CNT_WIDTH'(fifo_count) >= blen);
                if (m_axi_awvalid && m_axi_awready) begin
                    state_d = DATA;
                    beat_d  = 9'd0;
                end
            end
            DATA: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready) begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    addr_d      = addr_q + (32'(blen) << 2);
                    remaining_d = remaining_q - blen;
                    state_d     = (remaining_q == blen) ? DONE : ADDR;
                end
            end
            DONE: begin
                done = 1'b1;
`ifdef RING_BUF_EN
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    state_d     = (num_words == '0) ? DONE : ADDR;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            ready_en_q  <= 1'b1;
        end
    end

endmodule
